// File: rtl/mmio_pkg.sv
// Shared constants and register-select decode for the memory-mapped port responder.
// Also used by anything else that needs to address the three-register window.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0040;

  localparam logic [31:0] OFS_OUT    = 32'h0000_0000;
  localparam logic [31:0] OFS_IN     = 32'h0000_0004;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0008;

  localparam int CHG_BIT  = 0;
  localparam int WCNT_LSB = 8;
  localparam int WCNT_MSB = 15;

  typedef enum logic [1:0] {
    REG_OUT,
    REG_IN,
    REG_STATUS,
    REG_NONE
  } regSel_e;

  // Offsets are exact byte offsets, so unaligned or out-of-range addresses fall to REG_NONE.
  function automatic regSel_e decodeOffset(input logic [31:0] offset);
    regSel_e sel;
    case (offset)
      OFS_OUT:    sel = REG_OUT;
      OFS_IN:     sel = REG_IN;
      OFS_STATUS: sel = REG_STATUS;
      default:    sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchronizer for asynchronous external inputs; the last stage is the
// synchronized value. All stages clear on the asynchronous active-low reset.
module input_synchronizer #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncData,
  output logic [WIDTH-1:0] syncData
);

  logic [WIDTH-1:0] stageQ [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stageQ[i] <= '0;
      end
    end else begin
      stageQ[0] <= asyncData;
      for (int i = 1; i < STAGES; i++) begin
        stageQ[i] <= stageQ[i-1];
      end
    end
  end

  assign syncData = stageQ[STAGES-1];

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: OUT / IN / STATUS registers in a three-word window,
// a registered output port and a synchronized, change-tracked input port.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          IN_WIDTH    = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                Hit,
  output logic [31:0]         PortOut,
  output logic                ChangeIrq
);

  logic [31:0]         offset;
  regSel_e             regSel;
  logic [IN_WIDTH-1:0] inSync;
  logic [IN_WIDTH-1:0] prevIn;
  logic [31:0]         inWord;
  logic [31:0]         statusWord;
  logic [7:0]          wcnt;
  logic                chg;
  logic                wrOut;
  logic                wrStatus;
  logic                inChanged;

  input_synchronizer #(
    .WIDTH  (IN_WIDTH),
    .STAGES (SYNC_STAGES)
  ) uSync (
    .clk       (clk),
    .reset     (reset),
    .asyncData (PortIn),
    .syncData  (inSync)
  );

  assign offset = Address - BASE_ADDR;
  assign regSel = decodeOffset(offset);
  assign Hit    = (regSel != REG_NONE);

  assign wrOut     = MemWrite && (regSel == REG_OUT);
  assign wrStatus  = MemWrite && (regSel == REG_STATUS);
  assign inChanged = (inSync != prevIn);

  always_comb begin
    inWord               = '0;
    inWord[IN_WIDTH-1:0] = inSync;
  end

  always_comb begin
    statusWord                    = '0;
    statusWord[CHG_BIT]           = chg;
    statusWord[WCNT_MSB:WCNT_LSB] = wcnt;
  end

  // Zero-latency load path; anything not selected reads as zero so ReadData is never X.
  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      case (regSel)
        REG_OUT:    ReadData = PortOut;
        REG_IN:     ReadData = inWord;
        REG_STATUS: ReadData = statusWord;
        default:    ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut <= '0;
      wcnt    <= '0;
    end else if (wrOut) begin
      PortOut <= WriteData;
      wcnt    <= wcnt + 8'd1;
    end
  end

  // A pending change wins over a simultaneous write-1-to-clear so no edge is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevIn <= '0;
      chg    <= 1'b0;
    end else begin
      prevIn <= inSync;
      if (inChanged) begin
        chg <= 1'b1;
      end else if (wrStatus && WriteData[CHG_BIT]) begin
        chg <= 1'b0;
      end
    end
  end

  assign ChangeIrq = chg;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder; expected values go into a scoreboard queue
// when stimulus is driven and are popped and compared when the DUT output is sampled.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE        = 32'h1001_0040;
  localparam int          IN_WIDTH    = 8;
  localparam int          SYNC_STAGES = 2;

  localparam logic [31:0] A_OUT    = BASE + 32'h0;
  localparam logic [31:0] A_IN     = BASE + 32'h4;
  localparam logic [31:0] A_STATUS = BASE + 32'h8;

  logic                clk;
  logic                reset;
  logic [31:0]         Address;
  logic [31:0]         WriteData;
  logic                MemWrite;
  logic                MemRead;
  logic [IN_WIDTH-1:0] PortIn;
  logic [31:0]         ReadData;
  logic                Hit;
  logic [31:0]         PortOut;
  logic                ChangeIrq;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expect_t;

  expect_t sbQ[$];
  int      assertCount = 0;
  int      failCount   = 0;

  logic [31:0] expPortOut;
  logic [7:0]  expWcnt;
  logic        expChg;

  mmio_port_responder #(
    .BASE_ADDR   (BASE),
    .IN_WIDTH    (IN_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .PortIn    (PortIn),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortOut   (PortOut),
    .ChangeIrq (ChangeIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] statusOf(input logic [7:0] w, input logic c);
    return {16'h0, w, 7'h0, c};
  endfunction

  task automatic pushExpect(input string tag, input logic [31:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expect_t e;
    assertCount++;
    if (sbQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard: observed %h with no expected value queued", observed);
    end else begin
      e = sbQ.pop_front();
      assert (observed === e.value) else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
      end
    end
  endtask

  // One store cycle, committed at the next rising edge; returns 1ns after that edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic applyLoad(input logic [31:0] addr, input string tag, input logic [31:0] expValue);
    Address = addr;
    MemRead = 1'b1;
    pushExpect(tag, expValue);
    #1;
    checkOutput(ReadData);
    MemRead = 1'b0;
  endtask

  task automatic checkSignal(input string tag, input logic [31:0] observed, input logic [31:0] expValue);
    pushExpect(tag, expValue);
    checkOutput(observed);
  endtask

  initial begin
    reset      = 1'b0;
    Address    = '0;
    WriteData  = '0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    PortIn     = 8'h00;
    expPortOut = '0;
    expWcnt    = '0;
    expChg     = 1'b0;

    // Reset held: outputs cleared, decode still live
    repeat (3) @(posedge clk);
    #1;
    checkSignal("resetPortOut", PortOut, 32'h0);
    checkSignal("resetIrq", {31'h0, ChangeIrq}, 32'h0);
    applyLoad(A_IN, "resetInRead", 32'h0);
    applyLoad(A_STATUS, "resetStatus", 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
    checkSignal("idleIrq", {31'h0, ChangeIrq}, 32'h0);

    // Basic store / load
    applyStimulus(A_OUT, 32'hDEAD_BEEF);
    expPortOut = 32'hDEAD_BEEF;
    expWcnt    = expWcnt + 8'd1;
    checkSignal("storePortOut", PortOut, expPortOut);
    applyLoad(A_OUT, "loadOut", expPortOut);
    applyLoad(A_STATUS, "loadStatus", 32'h0000_0100);
    Address = A_OUT;
    #1;
    checkSignal("noReadZero", ReadData, 32'h0);

    // Synchronizer latency and change detect
    @(negedge clk);
    PortIn = 8'hA5;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      @(posedge clk);
      #1;
      applyLoad(A_IN, $sformatf("inSync%0d", k), (k >= SYNC_STAGES) ? 32'h0000_00A5 : 32'h0);
      checkSignal($sformatf("chgLatency%0d", k), {31'h0, ChangeIrq},
                  (k == SYNC_STAGES + 1) ? 32'h1 : 32'h0);
    end
    applyLoad(A_STATUS, "statusChgSet", statusOf(expWcnt, 1'b1));
    applyStimulus(A_STATUS, 32'h0000_0001);
    checkSignal("w1cClears", {31'h0, ChangeIrq}, 32'h0);

    // Change set and W1C on the same edge: set wins
    @(negedge clk);
    PortIn = 8'h3C;
    repeat (SYNC_STAGES) @(posedge clk);
    #1;
    checkSignal("preCollideIrq", {31'h0, ChangeIrq}, 32'h0);
    applyStimulus(A_STATUS, 32'h0000_0001);
    checkSignal("collideSetWins", {31'h0, ChangeIrq}, 32'h1);
    applyStimulus(A_STATUS, 32'hFFFF_FF01);
    checkSignal("w1cAfterCollide", {31'h0, ChangeIrq}, 32'h0);
    applyLoad(A_STATUS, "wcntNotWritable", statusOf(expWcnt, 1'b0));

    // WCNT wrap and ignored IN write
    for (int i = 0; i < 255; i++) begin
      applyStimulus(A_OUT, 32'h0101_0000 + i);
      expPortOut = 32'h0101_0000 + i;
      expWcnt    = expWcnt + 8'd1;
    end
    applyLoad(A_STATUS, "wcntWrap", statusOf(expWcnt, 1'b0));
    checkSignal("wrapPortOut", PortOut, expPortOut);
    applyStimulus(A_OUT, 32'h0000_5555);
    expPortOut = 32'h0000_5555;
    expWcnt    = expWcnt + 8'd1;
    applyLoad(A_STATUS, "wcntAfterWrap", statusOf(expWcnt, 1'b0));
    applyStimulus(A_IN, 32'hFFFF_FFFF);
    checkSignal("inWritePortOut", PortOut, expPortOut);
    applyLoad(A_STATUS, "inWriteWcnt", statusOf(expWcnt, 1'b0));
    applyLoad(A_IN, "inWriteIgnored", 32'h0000_003C);

    // Addresses outside the window
    Address = A_STATUS;
    #1;
    checkSignal("hitStatus", {31'h0, Hit}, 32'h1);
    for (int j = 0; j < 3; j++) begin
      logic [31:0] missAddr;
      missAddr = (j == 0) ? BASE + 32'h2 : (j == 1) ? BASE + 32'hC : 32'h1001_0000;
      Address = missAddr;
      MemRead = 1'b1;
      #1;
      checkSignal($sformatf("missHit%0d", j), {31'h0, Hit}, 32'h0);
      checkSignal($sformatf("missRead%0d", j), ReadData, 32'h0);
      MemRead = 1'b0;
      applyStimulus(missAddr, 32'hCAFE_F00D);
      checkSignal($sformatf("missPortOut%0d", j), PortOut, expPortOut);
      applyLoad(A_STATUS, $sformatf("missStatus%0d", j), statusOf(expWcnt, 1'b0));
    end

    // Read and write together: read sees the pre-write value
    @(negedge clk);
    Address   = A_OUT;
    WriteData = 32'h1234_ABCD;
    MemWrite  = 1'b1;
    MemRead   = 1'b1;
    #1;
    checkSignal("rmwReadOld", ReadData, expPortOut);
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    expPortOut = 32'h1234_ABCD;
    expWcnt    = expWcnt + 8'd1;
    checkSignal("rmwWriteNew", PortOut, expPortOut);

    // Asynchronous reset mid-cycle with a store pending
    @(negedge clk);
    Address   = A_OUT;
    WriteData = 32'h8765_4321;
    MemWrite  = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checkSignal("asyncPortOut", PortOut, 32'h0);
    applyLoad(A_IN, "inHeldReset", 32'h0);
    Address = A_OUT;
    @(posedge clk);
    #1;
    checkSignal("lostWrite", PortOut, 32'h0);
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b1;
    expPortOut = '0;
    expWcnt    = '0;
    #1;
    applyLoad(A_STATUS, "postResetStatus", 32'h0);
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      @(posedge clk);
      #1;
      checkSignal($sformatf("releaseChg%0d", k), {31'h0, ChangeIrq},
                  (k == SYNC_STAGES + 1) ? 32'h1 : 32'h0);
    end
    applyLoad(A_STATUS, "releaseStatus", statusOf(8'h00, 1'b1));
    checkSignal("releasePortOut", PortOut, expPortOut);

    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardDrain: observed %0d entries expected 0", sbQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor data bus. Sits beside the data memory and claims a small address window.
- Serves loads and stores from the processor core.
- Drives the external PortOut register and presents a synchronized, change-tracked PortIn.
- The top level muxes ReadData between this block and the data memory using Hit.

Parameters:
- BASE_ADDR, 32'h1001_0040, word-aligned base of the 3-register window.
- IN_WIDTH, 8, width of the external input port (1..32).
- SYNC_STAGES, 2, flops in the PortIn synchronizer chain (2..4).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data (rt register value).
- MemWrite  input  1  store strobe for the current cycle.
- MemRead  input  1  load strobe for the current cycle.
- PortIn  input  IN_WIDTH  external asynchronous input pins.
- ReadData  output  32  load data; combinational.
- Hit  output  1  Address falls in the window; combinational.
- PortOut  output  32  registered output port.
- ChangeIrq  output  1  level copy of STATUS.CHG.

Behaviour:
- Register map, byte offsets from BASE_ADDR:
  - 0x0 OUT: read/write.
  - 0x4 IN: read-only; synchronized PortIn, zero-extended to 32 bits.
  - 0x8 STATUS: bit0 CHG (sticky, write-1-to-clear); bits[15:8] WCNT; all other bits read 0, writes to them ignored.
- Hit = 1 only when Address is 0x0, 0x4 or 0x8 from BASE_ADDR with Address[1:0]==0. Unaligned or offset 0xC and above: Hit=0, no effect.
- ReadData = selected register when MemRead & Hit, else 32'h0. Zero latency, so a single-cycle load completes in its own cycle.
- Writes commit on the rising clk edge when MemWrite & Hit:
  - OUT: PortOut <= WriteData. WCNT increments by 1 and wraps 255->0.
  - IN: write ignored; WCNT unchanged.
  - STATUS: WriteData[0]=1 clears CHG. WriteData[15:8] is ignored (WCNT is not writable).
- Synchronizer: PortIn passes through SYNC_STAGES flops. The IN register is the last stage.
- Change detect:
  - prev <= IN every cycle.
  - CHG sets on the edge after IN != prev, so it is visible SYNC_STAGES+1 cycles after a PortIn change.
- Simultaneous CHG set and W1C in the same cycle: set wins, CHG stays 1.
- MemRead & MemWrite together on the same address: ReadData returns the pre-write value, and the write commits at the edge.
- Reset, asynchronous on reset low:
  - PortOut=0, WCNT=0, CHG=0, ChangeIrq=0.
  - All synchronizer stages and prev = 0.
  - A pending write is discarded.
  - ReadData and Hit remain combinational; IN reads 0 while reset is held.
- On reset release, a nonzero PortIn produces a CHG set SYNC_STAGES+1 cycles later. This is required behaviour.
- No X on ReadData for any Address value.

Decomposition:
- Shared package mmio_pkg:
  - Offset constants OFS_OUT=0, OFS_IN=4, OFS_STATUS=8.
  - STATUS bit positions CHG_BIT=0, WCNT_LSB=8, WCNT_MSB=15.
  - Default BASE_ADDR constant.
- One sub-module: input_synchronizer, parameterized by width and stage count, with async active-low reset. It is reused later for other external inputs.
- Address decode, register file and change detect stay in the top.

Test Plan:
- Reset low with PortIn=8'h00, then release; store 32'hDEAD_BEEF to BASE+0x0 -> PortOut=32'hDEADBEEF after the edge, load of BASE+0x0 returns the same value, load of BASE+0x8 returns 32'h0000_0100.
- PortIn steps 8'h00->8'hA5 -> IN reads 32'h0000_00A5 from SYNC_STAGES cycles later; CHG=1 and ChangeIrq=1 at SYNC_STAGES+1 cycles; store 32'h1 to BASE+0x8 -> CHG=0.
- PortIn changes on the same edge as a W1C store to STATUS -> CHG remains 1.
- 256 stores to BASE+0x0 -> WCNT wraps to 0; a store to BASE+0x4 leaves WCNT and PortOut unchanged.
- Address BASE+0x2, BASE+0xC and 32'h1001_0000 -> Hit=0, ReadData=0, a store there changes nothing.
- Assert reset low mid-cycle with MemWrite asserted to BASE+0x0 -> PortOut=0 immediately and the write is lost; CHG and WCNT read 0 after release.
